// File: rtl/data_mem_responder_if.sv
// Core-side load/store bus of the data-memory responder.
// The core is the master; the responder is the slave.
interface data_mem_responder_if;
  logic        req_read;
  logic        req_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        error;
  logic        stall;
  logic [7:0]  err_count;

  modport master (
    output req_read, req_write, addr, wdata,
    input  rdata, ready, error, stall, err_count
  );

  modport slave (
    input  req_read, req_write, addr, wdata,
    output rdata, ready, error, stall, err_count
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM answering core loads/stores after a fixed wait-state count.
// Latency WAIT_CYCLES+1 from acceptance to the ready pulse; stall holds the core meanwhile.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          rd_q, wr_q, err_q;
  logic [7:0]    err_cnt_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          req;
  logic          req_err;
  logic [AW-1:0] req_idx;
  logic          load_rdata;
  logic [AW-1:0] rd_idx;

  assign req     = bus.req_read | bus.req_write;
  assign req_err = (bus.addr[1:0] != 2'b00)
                 | (bus.addr[31:2] >= 30'(DEPTH_WORDS))
                 | (bus.req_read & bus.req_write);
  assign req_idx = bus.addr[AW+1:2];

  // State register plus the request copies latched at acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) begin
        idx_q   <= req_idx;
        wdata_q <= bus.wdata;
        rd_q    <= bus.req_read;
        wr_q    <= bus.req_write;
        err_q   <= req_err;
      end
      if (load_rdata) rdata_q <= mem_q[rd_idx];
      if (state_q == DONE && err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  // Write commits on the edge leaving DONE; a reset on that edge suppresses it
  always_ff @(posedge clk) begin
    if (!reset && state_q == DONE && wr_q && !err_q) mem_q[idx_q] <= wdata_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the read index comes straight from the bus
  always_comb begin
    bus.ready  = (state_q == DONE);
    bus.error  = (state_q == DONE) & err_q;
    bus.stall  = req & (state_q != DONE);
    load_rdata = 1'b0;
    rd_idx     = idx_q;
    if (state_q == IDLE) begin
      load_rdata = (state_d == DONE) & bus.req_read & ~req_err;
      rd_idx     = req_idx;
    end else if (state_q == WAIT) begin
      load_rdata = (state_d == DONE) & rd_q & ~err_q;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.err_count = err_cnt_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: transaction-level model of the responder checked every cycle, plus literal pins.
module tb_data_mem_responder;
  localparam int W = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if bus();
  data_mem_responder_if bus0();

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset), .bus(bus));
  data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  // Transaction model: one outstanding request, completion cycle, word memory
  logic [31:0] mem_m [256];
  bit          m_pend = 1'b0;
  int          m_done = 0;
  bit          m_err, m_rd, m_wr;
  int          m_idx;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = 32'h0;
  int          m_errcnt = 0;
  bit          er_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    m_pend  = 1'b1;
    m_done  = cyc + W + 1;
    m_rd    = rd;
    m_wr    = wr;
    m_wdata = d;
    m_err   = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256) || (rd && wr);
    m_idx   = int'(a[9:2]);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      er_m = m_pend && (cyc == m_done);
      if (er_m && m_rd && !m_err) m_rdata = mem_m[m_idx];
      check("ready", bus.ready, er_m);
      check("error", bus.error, er_m && m_err);
      check("stall", bus.stall, (bus.req_read || bus.req_write) && !er_m);
      check("rdata", bus.rdata, m_rdata);
      check("err_count", bus.err_count, m_errcnt);
      if (reset) begin
        m_pend   = 1'b0;
        m_rdata  = 32'h0;
        m_errcnt = 0;
      end else if (er_m) begin
        m_pend = 1'b0;
        if (m_err) begin
          if (m_errcnt < 255) m_errcnt++;
        end else if (m_wr) begin
          mem_m[m_idx] = m_wdata;
        end
      end
    end
  end

  // churn: 0 = hold inputs, 1 = scramble addr/wdata during WAIT, 2 = drop request during WAIT
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input int churn, output int lat);
    int  c0;
    bit  seen;
    @(posedge clk); #1;
    bus.req_read  = rd;
    bus.req_write = wr;
    bus.addr      = a;
    bus.wdata     = d;
    model_issue(rd, wr, a, d);
    c0   = cyc;
    seen = 1'b0;
    lat  = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.ready) begin
        seen = 1'b1;
        lat  = cyc - c0;
        break;
      end
      @(posedge clk); #1;
      if (churn == 1) begin
        bus.addr  = 32'h0000_000C;
        bus.wdata = 32'hBAD0_BAD0;
      end else if (churn == 2) begin
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
      end
    end
    if (!seen) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
  endtask

  task automatic w0_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit exp_err, input logic [31:0] exp_rdata);
    @(posedge clk); #1;
    bus0.req_read  = rd;
    bus0.req_write = wr;
    bus0.addr      = a;
    bus0.wdata     = d;
    @(negedge clk);
    check("w0_stall_req", bus0.stall, 1'b1);
    check("w0_ready_req", bus0.ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("w0_ready", bus0.ready, 1'b1);
    check("w0_stall_done", bus0.stall, 1'b0);
    check("w0_error", bus0.error, exp_err);
    check("w0_rdata", bus0.rdata, exp_rdata);
    @(posedge clk); #1;
    bus0.req_read  = 1'b0;
    bus0.req_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bus.req_read   = 1'b0;
    bus.req_write  = 1'b0;
    bus.addr       = 32'h0;
    bus.wdata      = 32'h0;
    bus0.req_read  = 1'b0;
    bus0.req_write = 1'b0;
    bus0.addr      = 32'h0;
    bus0.wdata     = 32'h0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset  = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_err_count", bus.err_count, 32'd0);
    check("reset_ready", bus.ready, 1'b0);

    // Aligned write then read
    do_req(0, 1, 32'h10, 32'hDEADBEEF, 0, lat);
    check("wr_latency", lat, 32'd3);
    do_req(1, 0, 32'h10, 32'h0, 0, lat);
    check("rd_latency", lat, 32'd3);
    check("rd_0x10", bus.rdata, 32'hDEADBEEF);

    // Misaligned store
    do_req(0, 1, 32'h13, 32'h12345678, 0, lat);
    check("misaligned_err_count", bus.err_count, 32'd1);
    do_req(1, 0, 32'h10, 32'h0, 0, lat);
    check("rd_after_misaligned", bus.rdata, 32'hDEADBEEF);

    do_req(0, 1, 32'h20, 32'hCAFEF00D, 0, lat);
    do_req(0, 1, 32'h0C, 32'h0C0C0C0C, 0, lat);

    // Out of range, then drive the error counter into saturation
    do_req(1, 0, 32'h400, 32'h0, 0, lat);
    check("oor_rdata_held", bus.rdata, 32'hDEADBEEF);
    check("oor_err_count", bus.err_count, 32'd2);
    for (int i = 0; i < 256; i++)
      do_req(i[0], ~i[0], 32'h400 + 32'(i * 4), 32'(i), 0, lat);
    check("err_count_sat", bus.err_count, 32'd255);

    // Conflicting request leaves memory alone
    do_req(1, 1, 32'h10, 32'hFFFFFFFF, 0, lat);
    check("conflict_err_count", bus.err_count, 32'd255);
    do_req(1, 0, 32'h10, 32'h0, 0, lat);
    check("rd_after_conflict", bus.rdata, 32'hDEADBEEF);

    // Input churn and request drop during WAIT
    do_req(0, 1, 32'h08, 32'h11111111, 1, lat);
    do_req(1, 0, 32'h08, 32'h0, 0, lat);
    check("churn_0x08", bus.rdata, 32'h11111111);
    do_req(1, 0, 32'h0C, 32'h0, 0, lat);
    check("churn_0x0C_untouched", bus.rdata, 32'h0C0C0C0C);
    do_req(0, 1, 32'h14, 32'h77777777, 2, lat);
    check("drop_latency", lat, 32'd3);
    do_req(1, 0, 32'h14, 32'h0, 0, lat);
    check("drop_0x14", bus.rdata, 32'h77777777);

    // Zero-wait-state instance
    w0_req(0, 1, 32'h4, 32'h00000055, 1'b0, 32'h0);
    w0_req(1, 0, 32'h4, 32'h0, 1'b0, 32'h00000055);
    w0_req(1, 1, 32'h4, 32'h00000099, 1'b1, 32'h00000055);
    w0_req(1, 0, 32'h4, 32'h0, 1'b0, 32'h00000055);
    w0_req(1, 0, 32'h6, 32'h0, 1'b1, 32'h00000055);
    w0_req(1, 0, 32'h40, 32'h0, 1'b1, 32'h00000055);

    // Reset in the second WAIT cycle of a write
    @(posedge clk); #1;
    bus.req_read  = 1'b0;
    bus.req_write = 1'b1;
    bus.addr      = 32'h20;
    bus.wdata     = 32'hA5A5A5A5;
    model_issue(0, 1, 32'h20, 32'hA5A5A5A5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req_write = 1'b0;
    @(negedge clk);
    check("rst_wait_ready", bus.ready, 1'b0);
    check("rst_wait_error", bus.error, 1'b0);
    check("rst_wait_rdata", bus.rdata, 32'h0);
    check("rst_wait_err_count", bus.err_count, 32'd0);
    check("rst_wait_stall", bus.stall, 1'b0);
    do_req(1, 0, 32'h20, 32'h0, 0, lat);
    check("rst_wait_0x20", bus.rdata, 32'hCAFEF00D);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
